// File: rtl/button_pkg.sv
// button_pkg -- shared types and helpers for button_press_classifier.
//   state_t        : classifier FSM states
//   EVT_*          : event-type encoding carried in the registered event field
//   ms_to_cycles() : millisecond interval -> clock-cycle count
//   max3()         : largest of three counts, sizes the shared counter
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT_GAP,
        PRESS2,
        HELD
    } state_t;

    localparam logic [2:0] EVT_NONE   = 3'd0;
    localparam logic [2:0] EVT_SINGLE = 3'd1;
    localparam logic [2:0] EVT_DOUBLE = 3'd2;
    localparam logic [2:0] EVT_LONG   = 3'd3;
    localparam logic [2:0] EVT_REPEAT = 3'd4;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                                 input int unsigned ms);
        return (clk_freq / 1000) * ms;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_press_classifier_if.sv
// button_press_classifier_if -- debounced button level in, gesture events out.
//   btn_in       : debounced level, 1 = pressed
//   single_pulse : one-cycle single-click event
//   double_pulse : one-cycle double-click event
//   long_pulse   : one-cycle long-press event
//   repeat_pulse : one-cycle auto-repeat event (0 unless BTN_AUTOREPEAT_EN)
//   busy         : classifier is mid-gesture (FSM not IDLE)
// master = the side driving the button (bench / upstream), slave = classifier.
interface button_press_classifier_if;
    logic btn_in;
    logic single_pulse;
    logic double_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic busy;

    modport master (
        output btn_in,
        input  single_pulse, double_pulse, long_pulse, repeat_pulse, busy
    );

    modport slave (
        input  btn_in,
        output single_pulse, double_pulse, long_pulse, repeat_pulse, busy
    );
endinterface

// File: rtl/btn_edge_detect.sv
// btn_edge_detect -- registers the previous button level and the post-reset
// init flag, and derives rise/fall from them.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_btn      : debounced button level
//   o_rise     : i_btn & ~btn_d
//   o_fall     : ~i_btn & btn_d
//   o_init     : high for the first cycle after reset only
// btn_d resets to 0, so o_rise can be high in the init cycle; the consumer
// must ignore edges while o_init is set.
module btn_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_rise,
    output logic o_fall,
    output logic o_init
);
    logic r_btn_d;
    logic r_init;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_d <= 1'b0;
            r_init  <= 1'b1;
        end else begin
            r_btn_d <= i_btn;
            r_init  <= 1'b0;
        end
    end

    assign o_rise = i_btn & ~r_btn_d;
    assign o_fall = ~i_btn & r_btn_d;
    assign o_init = r_init;
endmodule

// File: rtl/button_press_classifier.sv
// button_press_classifier -- classifies debounced button gestures into
// single click, double click and long press, one registered pulse each.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : button_press_classifier_if.slave (btn_in, event pulses, busy)
// Optional build macro BTN_AUTOREPEAT_EN: while HELD after a long press,
// emit repeat_pulse every REP_CNT cycles. Without it repeat_pulse is 0.
// One shared counter serves the long-press, gap and repeat timers; it is
// cleared on every state change and is compared against (count-1), so an
// event lands exactly count cycles after the state was entered.
module button_press_classifier
    import button_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned LONG_PRESS_MS = 1000,
    parameter int unsigned DOUBLE_GAP_MS = 300,
    parameter int unsigned REPEAT_MS     = 200
) (
    input  logic                       clk,
    input  logic                       rst_n,
    button_press_classifier_if.slave   bus
);
    localparam int unsigned LONG_CNT = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);
    localparam int unsigned GAP_CNT  = ms_to_cycles(CLK_FREQ, DOUBLE_GAP_MS);
    localparam int unsigned REP_CNT  = ms_to_cycles(CLK_FREQ, REPEAT_MS);
    localparam int          CW       = $clog2(max3(LONG_CNT, GAP_CNT, REP_CNT)) + 1;

    localparam logic [CW-1:0] LONG_M1 = CW'(LONG_CNT - 1);
    localparam logic [CW-1:0] GAP_M1  = CW'(GAP_CNT - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CW-1:0] REP_M1  = CW'(REP_CNT - 1);
`endif

    logic          w_rise;
    logic          w_fall;
    logic          w_init;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic [2:0]    r_evt,   w_evt_nxt;
    logic          r_busy;
`ifdef BTN_AUTOREPEAT_EN
    // Set only when HELD is reached by a genuine long press; HELD reached
    // from a button held through reset must stay silent.
    logic          r_rep_ok, w_rep_ok_nxt;
`endif

    btn_edge_detect u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (bus.btn_in),
        .o_rise (w_rise),
        .o_fall (w_fall),
        .o_init (w_init)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_evt_nxt   = EVT_NONE;
`ifdef BTN_AUTOREPEAT_EN
        w_rep_ok_nxt = r_rep_ok;
`endif
        if (w_init) begin
            // Button already down at reset release: park in HELD until it
            // is let go, without generating any event.
            if (bus.btn_in) begin
                w_state_nxt = HELD;
`ifdef BTN_AUTOREPEAT_EN
                w_rep_ok_nxt = 1'b0;
`endif
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) w_state_nxt = PRESS1;
                end
                PRESS1: begin
                    // fall checked first: a release on the last count wins
                    if (w_fall) begin
                        w_state_nxt = WAIT_GAP;
                    end else if (r_cnt == LONG_M1) begin
                        w_evt_nxt   = EVT_LONG;
                        w_state_nxt = HELD;
`ifdef BTN_AUTOREPEAT_EN
                        w_rep_ok_nxt = 1'b1;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                WAIT_GAP: begin
                    // rise checked first: a second press on the last count wins
                    if (w_rise) begin
                        w_state_nxt = PRESS2;
                    end else if (r_cnt == GAP_M1) begin
                        w_evt_nxt   = EVT_SINGLE;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                PRESS2: begin
                    if (w_fall) begin
                        w_evt_nxt   = EVT_DOUBLE;
                        w_state_nxt = IDLE;
                    end
                end
                HELD: begin
                    if (w_fall) begin
                        w_state_nxt = IDLE;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (r_rep_ok) begin
                        if (r_cnt == REP_M1) begin
                            w_evt_nxt = EVT_REPEAT;
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
`endif
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_evt   <= EVT_NONE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_evt   <= w_evt_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rep_ok <= 1'b0;
        else        r_rep_ok <= w_rep_ok_nxt;
    end
`endif

    // A single encoded event register makes the pulses mutually exclusive.
    assign bus.single_pulse = (r_evt == EVT_SINGLE);
    assign bus.double_pulse = (r_evt == EVT_DOUBLE);
    assign bus.long_pulse   = (r_evt == EVT_LONG);
`ifdef BTN_AUTOREPEAT_EN
    assign bus.repeat_pulse = (r_evt == EVT_REPEAT);
`else
    assign bus.repeat_pulse = 1'b0;
`endif
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_button_press_classifier.sv
// Scoreboard bench for button_press_classifier with LONG_CNT=50, GAP_CNT=20,
// REP_CNT=10. Stimulus pushes {event kind, expected cycle} before the pulse
// can occur; the monitor pops and compares on every pulse, and flags pulses
// that never arrive. Cycle numbers count rising edges since time 0.
module tb_button_press_classifier;
    localparam int K_SINGLE = 1;
    localparam int K_DOUBLE = 2;
    localparam int K_LONG   = 3;
    localparam int K_REPEAT = 4;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    button_press_classifier_if bus ();

    button_press_classifier #(
        .CLK_FREQ      (10_000),
        .LONG_PRESS_MS (5),
        .DOUBLE_GAP_MS (2),
        .REPEAT_MS     (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge: the new level is sampled at the next rising edge,
    // whose number is returned.
    task automatic drive(input logic v, output int e);
        bus.btn_in = v;
        e = cyc + 1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_evt(input int kind, input int c);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        q.push_back(e);
    endtask

    function automatic int outs();
        return {bus.single_pulse, bus.double_pulse, bus.long_pulse,
                bus.repeat_pulse, bus.busy};
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin : mon
        int n;
        int kind;
        exp_t e;
        n = int'(bus.single_pulse) + int'(bus.double_pulse) +
            int'(bus.long_pulse) + int'(bus.repeat_pulse);
        kind = bus.single_pulse ? K_SINGLE : bus.double_pulse ? K_DOUBLE :
               bus.long_pulse   ? K_LONG   : K_REPEAT;
        if (n != 0) begin
            checks++;
            if (n > 1) begin
                errors++;
                $display("FAIL multi_pulse: %0d pulses high at cycle %0d, at most 1 allowed", n, cyc);
            end else if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected", kind, cyc);
            end else begin
                e = q.pop_front();
                if (e.kind != kind || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                             kind, cyc, e.kind, e.cyc);
                end
            end
        end else if (q.size() != 0 && q[0].cyc < cyc) begin
            checks++;
            errors++;
            e = q.pop_front();
            $display("FAIL missing_pulse: kind %0d expected at cycle %0d, not seen by %0d",
                     e.kind, e.cyc, cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, tf, t2, t3;
        bus.btn_in = 1'b0;

        // Reset values
        wait_n(3);
        chk("reset_outputs", outs(), 0);
        rst_n = 1'b1;
        wait_n(5);
        chk("idle_busy", int'(bus.busy), 0);

        // Single click: press 10, release -> single 20 cycles after the fall
        drive(1'b1, t0); wait_n(10);
        drive(1'b0, tf);
        expect_evt(K_SINGLE, tf + 20);
        wait_n(5);
        chk("single_busy_in_gap", int'(bus.busy), 1);
        wait_n(25);
        chk("single_busy_after", int'(bus.busy), 0);

        // Double click: press 10, release 8, press 10, release
        drive(1'b1, t0); wait_n(10);
        drive(1'b0, tf); wait_n(8);
        drive(1'b1, t2); wait_n(10);
        chk("double_busy_press2", int'(bus.busy), 1);
        drive(1'b0, t3);
        expect_evt(K_DOUBLE, t3);
        wait_n(30);
        chk("double_busy_after", int'(bus.busy), 0);

        // Long press held 85 cycles: long at +50, repeats at +60/+70/+80
        drive(1'b1, t0);
        expect_evt(K_LONG, t0 + 50);
`ifdef BTN_AUTOREPEAT_EN
        expect_evt(K_REPEAT, t0 + 60);
        expect_evt(K_REPEAT, t0 + 70);
        expect_evt(K_REPEAT, t0 + 80);
`endif
        wait_n(85);
        chk("long_busy_held", int'(bus.busy), 1);
        drive(1'b0, tf); wait_n(10);
        chk("long_busy_after", int'(bus.busy), 0);

        // Release exactly on counter 49: no long, single follows
        drive(1'b1, t0); wait_n(50);
        drive(1'b0, tf);
        expect_evt(K_SINGLE, tf + 20);
        wait_n(30);

        // Second press on the last gap cycle: double, no single
        drive(1'b1, t0); wait_n(10);
        drive(1'b0, tf); wait_n(20);
        drive(1'b1, t2); wait_n(10);
        drive(1'b0, t3);
        expect_evt(K_DOUBLE, t3);
        wait_n(30);

        // Button held through reset: no events at all until released
        rst_n = 1'b0;
        bus.btn_in = 1'b1;
        wait_n(3);
        rst_n = 1'b1;
        wait_n(70);
        chk("held_thru_reset_busy", int'(bus.busy), 1);
        drive(1'b0, tf); wait_n(30);
        chk("held_thru_reset_released", int'(bus.busy), 0);

        // Reset asserted mid WAIT_GAP: outputs clear at once, no single later
        drive(1'b1, t0); wait_n(10);
        drive(1'b0, tf); wait_n(5);
        chk("gap_busy_before_reset", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_gap_reset_outputs", outs(), 0);
        wait_n(3);
        rst_n = 1'b1;
        wait_n(40);
        chk("after_mid_gap_reset_busy", int'(bus.busy), 0);

        // Fresh single click after reset still classifies
        drive(1'b1, t0); wait_n(10);
        drive(1'b0, tf);
        expect_evt(K_SINGLE, tf + 20);
        wait_n(30);

        chk("scoreboard_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
